// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared definitions for the one-hot ring counter and its downstream checker.
//   - state_t   : checker FSM state encoding (SYNC/LOCKED/FAULT, 2 bits).
//   - DEF_WIDTH : default ring length.
//   - DEF_CNT_W : default rotation counter width.
//   - rotl1     : rotate-left-by-one for any ring length up to MAX_W bits.
// ---------------------------------------------------------------------------
package ring_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Rotates the low w bits of v left by one (MSB wraps to bit 0).
    // Bits of v at position w and above must be zero; the result is masked
    // to w bits so the caller can simply slice [w-1:0].
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                               input int unsigned       w);
        logic [MAX_W-1:0] mask;
        mask = '1;
        if (w < MAX_W) begin
            mask = (MAX_W'(1) << w) - MAX_W'(1);
        end
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// ---------------------------------------------------------------------------
// onehot_encoder
// Combinational one-hot to binary index encoder with a legality flag.
// Shared with the Johnson-counter decoder.
// Ports:
//   vec    in  WIDTH  candidate one-hot vector
//   idx    out PH_W   index of the set bit (meaningful only when onehot=1)
//   onehot out 1      vec has exactly one bit set
// ---------------------------------------------------------------------------
module onehot_encoder #(
    parameter int WIDTH = 4,
    parameter int PH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [PH_W-1:0]  idx,
    output logic             onehot
);

    assign onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

    // OR of the indices of all set bits: exact for a legal one-hot input,
    // and avoids a priority chain.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = idx | PH_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_phase_checker.sv
// ---------------------------------------------------------------------------
// ring_phase_checker
// Downstream monitor for the one-hot ring counter. Every clock it checks that
// ring_in is one-hot and is the correct successor of the last legal sample
// (rotated by one when adv=1, unchanged otherwise). Reports a registered
// phase index, a wrap pulse on the MSB->bit0 step, a rotation counter and
// sticky error flags.
//
// Build option: RING_CNT_SAT_EN -- when defined, rot_count saturates at
// all-ones instead of wrapping.
//
// Ports:
//   clk          in  1      rising-edge clock (same as the ring counter)
//   rst          in  1      asynchronous reset, active-high
//   ring_in      in  WIDTH  ring counter outputs
//   adv          in  1      ring advanced on this edge
//   clr_err      in  1      clear sticky errors; FAULT -> SYNC
//   phase        out PH_W   index of the set bit in the last legal sample
//   phase_valid  out 1      high in LOCKED only
//   wrap         out 1      one-cycle pulse on a legal WIDTH-1 -> 0 step
//   rot_count    out CNT_W  completed rotations since reset
//   err_onehot   out 1      sticky: a sample was not exactly one-hot
//   err_seq      out 1      sticky: one-hot sample with the wrong successor
//   state_o      out 2      FSM state, for debug
// ---------------------------------------------------------------------------
module ring_phase_checker
    import ring_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    localparam int PH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             adv,
    input  logic             clr_err,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             wrap,
    output logic [CNT_W-1:0] rot_count,
    output logic             err_onehot,
    output logic             err_seq,
    output logic [1:0]       state_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_r, prev_d;
    logic [PH_W-1:0]    phase_d;
    logic               wrap_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_onehot_d, err_seq_d;

    logic [PH_W-1:0]    enc_idx;
    logic               enc_onehot;
    logic [MAX_W-1:0]   rot_full;
    logic [WIDTH-1:0]   expected;

    onehot_encoder #(.WIDTH(WIDTH), .PH_W(PH_W)) u_enc (
        .vec    (ring_in),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign rot_full = rotl1(MAX_W'(prev_r), WIDTH);
    assign expected = adv ? rot_full[WIDTH-1:0] : prev_r;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_r;
        phase_d      = phase;
        wrap_d       = 1'b0;
        cnt_d        = rot_count;
        // A new error detected below overrides this clear.
        err_onehot_d = clr_err ? 1'b0 : err_onehot;
        err_seq_d    = clr_err ? 1'b0 : err_seq;

        unique case (state_q)
            SYNC: begin
                // Non-one-hot samples are ignored here so the all-zero
                // window after reset does not raise an error.
                if (enc_onehot) begin
                    prev_d  = ring_in;
                    phase_d = enc_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!enc_onehot) begin
                    err_onehot_d = 1'b1;
                    state_d      = FAULT;
                end else if (ring_in != expected) begin
                    err_seq_d = 1'b1;
                    state_d   = FAULT;
                end else begin
                    prev_d  = ring_in;
                    phase_d = enc_idx;
                    if (adv && prev_r[WIDTH-1] && ring_in[0]) begin
                        wrap_d = 1'b1;
`ifdef RING_CNT_SAT_EN
                        if (rot_count != '1) begin
                            cnt_d = rot_count + CNT_W'(1);
                        end
`else
                        cnt_d = rot_count + CNT_W'(1);
`endif
                    end
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_d = SYNC;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            prev_r     <= '0;
            phase      <= '0;
            wrap       <= 1'b0;
            rot_count  <= '0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values, matching real flops regardless of statement order.
            state_q    <= state_d;
            prev_r     <= prev_d;
            phase      <= phase_d;
            wrap       <= wrap_d;
            rot_count  <= cnt_d;
            err_onehot <= err_onehot_d;
            err_seq    <= err_seq_d;
        end
    end

    assign phase_valid = (state_q == LOCKED);
    assign state_o     = state_q;

endmodule
